// File: rtl/scfifo_s_pkg.sv
// Shared constants and helpers for the scfifo_s read-side adapters.
package scfifo_s_pkg;

    localparam int MAX_READ_LATENCY = 3;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int clog2p1(input int n);
        int w;
        w = 0;
        while ((1 << w) < (n + 1)) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/scfifo_s_regbuf.sv
// Small circular register FIFO with push/pop/count; head word is always visible.
module scfifo_s_regbuf
    import scfifo_s_pkg::*;
#(
    parameter  int WIDTH = 20,
    parameter  int DEPTH = 3,
    localparam int CNT_W = clog2p1(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             sclr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid  = (count_q != '0);
    assign do_pop = pop && valid;
    assign data   = mem_q[rd_ptr_q];
    assign count  = count_q;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !do_pop)
            count_d = count_q + CNT_W'(1);
        else if (!push && do_pop)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count is non-zero.
    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/scfifo_s_stream_out.sv
// Read-side adapter for a normal-mode scfifo_s: issues rdreq, tracks read latency, and
// presents a valid/ready stream whose ready never reaches fifo_rdreq combinationally.
module scfifo_s_stream_out
    import scfifo_s_pkg::*;
#(
    parameter  int WIDTH        = 20,
    parameter  int READ_LATENCY = 1,
    localparam int BUF_DEPTH    = READ_LATENCY + 2,
    localparam int CNT_W        = clog2p1(BUF_DEPTH)
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             sclr,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rdreq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int              OCC_W     = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_LIM = OCC_W'(BUF_DEPTH);

    logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [CNT_W-1:0]        inflight_cnt_q, inflight_cnt_d;
    logic [OCC_W-1:0]        occupancy;
    logic                    ret;

    assign ret       = vld_pipe_q[READ_LATENCY-1];
    assign occupancy = {1'b0, inflight_cnt_q} + {1'b0, out_count};
    // Only issue a read when a buffer slot is reserved for its return.
    assign fifo_rdreq = !fifo_empty && (occupancy < DEPTH_LIM) && !sclr;

    always_comb begin
        vld_pipe_d     = vld_pipe_q << 1;
        vld_pipe_d[0]  = fifo_rdreq;
        inflight_cnt_d = inflight_cnt_q;
        if (fifo_rdreq && !ret)
            inflight_cnt_d = inflight_cnt_q + CNT_W'(1);
        else if (!fifo_rdreq && ret)
            inflight_cnt_d = inflight_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            vld_pipe_q     <= '0;
            inflight_cnt_q <= '0;
        end else if (sclr) begin
            vld_pipe_q     <= '0;
            inflight_cnt_q <= '0;
        end else begin
            vld_pipe_q     <= vld_pipe_d;
            inflight_cnt_q <= inflight_cnt_d;
        end
    end

    scfifo_s_regbuf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock     (clock),
        .aclr      (aclr),
        .sclr      (sclr),
        .push      (ret),
        .push_data (fifo_q),
        .pop       (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .count     (out_count)
    );

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clock) disable iff (aclr)
        occupancy <= DEPTH_LIM);
    a_latency_range: assert property (@(posedge clock)
        READ_LATENCY >= 1 && READ_LATENCY <= MAX_READ_LATENCY);
`endif

endmodule

// File: tb/tb_scfifo_s_stream_out.sv
// Bench for scfifo_s_stream_out: two instances (READ_LATENCY 1 and 3) share stimulus, each
// fed by a queue-based upstream FIFO and checked against a word-order scoreboard.
module tb_scfifo_s_stream_out;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         aclr, sclr, out_ready, wr_en;
    logic [W-1:0] wr_data;
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int L  = (g == 0) ? 1 : 3;
        localparam int BD = L + 2;
        localparam int CW = $clog2(BD + 1);

        logic          fifo_empty, fifo_rdreq, out_valid;
        logic [W-1:0]  fifo_q, out_data, pop_w;
        logic [CW-1:0] out_count;
        logic [W-1:0]  upq[$];
        logic [W-1:0]  expq[$];
        logic [W-1:0]  dl [L];
        int            rdreq_cnt = 0;
        int            acc_cnt = 0;

        scfifo_s_stream_out #(.WIDTH(W), .READ_LATENCY(L)) dut (
            .clock      (clk),
            .aclr       (aclr),
            .sclr       (sclr),
            .fifo_empty (fifo_empty),
            .fifo_q     (fifo_q),
            .fifo_rdreq (fifo_rdreq),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_data   (out_data),
            .out_count  (out_count)
        );

        // Upstream FIFO: unbounded queue, q appears L edges after the rdreq edge.
        always @(posedge clk or posedge aclr) begin
            if (aclr) begin
                upq.delete();
                expq.delete();
                fifo_empty <= 1'b1;
                fifo_q     <= '0;
            end else begin
                pop_w = '1;
                if (sclr) begin
                    upq.delete();
                    expq.delete();
                end else if (fifo_rdreq && upq.size() != 0) begin
                    pop_w = upq.pop_front();
                    rdreq_cnt++;
                end
                for (int k = L - 1; k > 0; k--) dl[k] = dl[k-1];
                dl[0] = pop_w;
                if (wr_en && !sclr) begin
                    upq.push_back(wr_data);
                    expq.push_back(wr_data);
                end
                fifo_empty <= (upq.size() == 0);
                fifo_q     <= dl[L-1];
            end
        end

        // Every word leaving must be the oldest one written and not yet accepted.
        always @(negedge clk) begin
            if (!aclr && !sclr) begin
                vectors++;
                if (fifo_rdreq && fifo_empty) begin
                    miscompares++;
                    $display("FAIL ch%0d underflow: fifo_rdreq=1 while fifo_empty=1", g);
                end
                vectors++;
                if (int'(out_count) > BD) begin
                    miscompares++;
                    $display("FAIL ch%0d count: out_count=%0d exceeds %0d", g, out_count, BD);
                end
                if (out_valid) begin
                    vectors++;
                    if (expq.size() == 0) begin
                        miscompares++;
                        $display("FAIL ch%0d spurious: out_data=0x%0h with nothing outstanding", g, out_data);
                    end else if (out_data !== expq[0]) begin
                        miscompares++;
                        $display("FAIL ch%0d order: out_data=0x%0h, expected 0x%0h", g, out_data, expq[0]);
                    end
                    if (out_ready && expq.size() != 0) begin
                        void'(expq.pop_front());
                        acc_cnt++;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((ch[0].expq.size() != 0 || ch[1].expq.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain in time", 32'(n < 1000), 1);
        @(negedge clk);
        chk("drain idle ch0", ch[0].out_valid, 0);
        chk("drain idle ch1", ch[1].out_valid, 0);
    endtask

    logic         v_log [2][14];
    logic [W-1:0] d_log [2][14];
    int           r0, r1, a0, a1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aclr = 1'b0; sclr = 1'b0; out_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
        #1 aclr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid ch0", ch[0].out_valid, 0);
        chk("reset valid ch1", ch[1].out_valid, 0);
        chk("reset rdreq ch0", ch[0].fifo_rdreq, 0);
        chk("reset count ch1", ch[1].out_count, 0);
        aclr = 1'b0;
        @(negedge clk);
        chk("idle rdreq ch1", ch[1].fifo_rdreq, 0);
        chk("idle count ch0", ch[0].out_count, 0);

        // Streaming: words 1..8 with ready held high.
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            wr_en   = (c < 8);
            wr_data = W'(c + 1);
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                v_log[g][c] = (g == 0) ? ch[0].out_valid : ch[1].out_valid;
                d_log[g][c] = (g == 0) ? ch[0].out_data  : ch[1].out_data;
            end
        end
        wr_en = 1'b0;
        chk("stream0 before first", v_log[0][2], 0);
        chk("stream0 after last", v_log[0][11], 0);
        chk("stream1 before first", v_log[1][4], 0);
        chk("stream1 after last", v_log[1][13], 0);
        for (int i = 0; i < 8; i++) begin
            chk("stream0 valid", v_log[0][3+i], 1);
            chk("stream0 data", 32'(d_log[0][3+i]), i + 1);
            chk("stream1 valid", v_log[1][5+i], 1);
            chk("stream1 data", 32'(d_log[1][5+i]), i + 1);
        end
        drain();

        // Backpressure: 10 words, consumer stalled.
        out_ready = 1'b0;
        r0 = ch[0].rdreq_cnt; r1 = ch[1].rdreq_cnt;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_data = W'('h100 + i);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp rdreq pulses ch0", ch[0].rdreq_cnt - r0, 3);
        chk("bp rdreq pulses ch1", ch[1].rdreq_cnt - r1, 5);
        chk("bp count ch0", ch[0].out_count, 3);
        chk("bp count ch1", ch[1].out_count, 5);
        chk("bp valid ch0", ch[0].out_valid, 1);
        chk("bp held data ch0", 32'(ch[0].out_data), 'h100);
        chk("bp held data ch1", 32'(ch[1].out_data), 'h100);
        chk("bp rdreq off ch0", ch[0].fifo_rdreq, 0);
        drain();

        // Random ready over 200 words.
        a0 = ch[0].acc_cnt; a1 = ch[1].acc_cnt;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_data = W'('h300 + i);
            out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        drain();
        chk("random delivered ch0", ch[0].acc_cnt - a0, 200);
        chk("random delivered ch1", ch[1].acc_cnt - a1, 200);

        // sclr with two reads in flight and two words buffered on the latency-3 channel.
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            wr_en   = (c < 4);
            wr_data = W'('h400 + c);
            sclr    = (c == 6);
            @(negedge clk);
            if (c == 6) begin
                chk("pre-sclr count ch1", ch[1].out_count, 2);
                chk("pre-sclr valid ch1", ch[1].out_valid, 1);
            end
            if (c == 7) begin
                chk("sclr valid ch0", ch[0].out_valid, 0);
                chk("sclr valid ch1", ch[1].out_valid, 0);
                chk("sclr count ch0", ch[0].out_count, 0);
                chk("sclr count ch1", ch[1].out_count, 0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wr_en = (i < 3); wr_data = W'('h500 + i);
        end
        wr_en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("post-sclr data ch0", 32'(ch[0].out_data), 'h500);
        chk("post-sclr data ch1", 32'(ch[1].out_data), 'h500);
        chk("post-sclr count ch1", ch[1].out_count, 3);
        drain();

        // aclr pulse between edges while reads are still being issued.
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_data = W'('h600 + c);
            @(negedge clk);
        end
        chk("pre-aclr valid ch1", ch[1].out_valid, 1);
        chk("pre-aclr rdreq ch1", ch[1].fifo_rdreq, 1);
        #2 aclr = 1'b1;
        #1;
        chk("aclr valid ch0", ch[0].out_valid, 0);
        chk("aclr valid ch1", ch[1].out_valid, 0);
        chk("aclr rdreq ch1", ch[1].fifo_rdreq, 0);
        chk("aclr count ch1", ch[1].out_count, 0);
        #1 aclr = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scfifo_s_stream_out.md
Name: scfifo_s_stream_out

Overview:
- Read-side adapter placed directly downstream of an scfifo_s instance in normal mode (SHOW_AHEAD=0).
- Drives the FIFO's rdreq and absorbs the fixed read latency from rdreq to q.
- Presents a valid/ready stream to the consumer and sustains one word per cycle.
- Out_ready never combinationally affects fifo_rdreq, so consumer timing stays decoupled from the MLAB FIFO.

Parameters:
- WIDTH, 20, data width; must equal the WIDTH of the upstream FIFO.
- READ_LATENCY, 1, cycles from fifo_rdreq to valid fifo_q; legal range 1..3.
- BUF_DEPTH (localparam), READ_LATENCY+2, number of entries in the output register buffer.
- CNT_W (localparam), $clog2(BUF_DEPTH+1), width of the occupancy counters.

Ports:
- clock  in  1  single clock domain.
- aclr  in  1  asynchronous reset, active-high.
- sclr  in  1  synchronous clear, active-high.
- fifo_empty  in  1  empty flag from the upstream FIFO.
- fifo_q  in  WIDTH  q from the upstream FIFO.
- fifo_rdreq  out  1  rdreq to the upstream FIFO.
- out_valid  out  1  output word is valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  output word.
- out_count  out  CNT_W  words currently held in the buffer.

Behaviour:
- Reset (aclr asserted async, or sclr at the clock edge):
  - inflight_cnt=0, buffer pointers=0, out_count=0, out_valid=0, fifo_rdreq=0.
  - Valid shift register cleared.
  - out_data is don't-care after reset; the bench checks it only while out_valid=1.
- Read issue:
  - fifo_rdreq = !fifo_empty && (inflight_cnt + out_count < BUF_DEPTH) && !sclr.
  - Depends on registered state, fifo_empty and sclr only; never on out_ready.
  - Never asserted while fifo_empty=1, so the upstream FIFO cannot underflow.
- Read return:
  - A READ_LATENCY-deep valid shift register tracks each issued read.
  - When the shift register's tail bit is 1, fifo_q is written into the buffer on that edge.
- inflight_cnt update: +1 on rdreq, -1 on return, unchanged when both happen in the same cycle.
- Buffer:
  - Circular register array of BUF_DEPTH entries.
  - Write and read pointers wrap from BUF_DEPTH-1 to 0.
  - out_valid = (out_count != 0); out_data = entry at the read pointer.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave out_count unchanged.
- Overflow is impossible by construction: inflight_cnt + out_count <= BUF_DEPTH at all times. Provide an assertion for it (simulation only).
- Latency and throughput:
  - First word: out_valid rises READ_LATENCY+1 cycles after fifo_empty falls, given a free buffer.
  - With out_ready=1 and a non-empty FIFO: one word per cycle in steady state, no bubbles.
- Backpressure:
  - out_ready=0 holds out_data and out_valid stable; no change until acceptance.
  - fifo_rdreq stops once the buffer plus in-flight reads total BUF_DEPTH.
- sclr mid-operation: in-flight reads and buffered words are discarded. Drive sclr on the upstream FIFO in the same cycle.
- Ordering: words leave in exactly FIFO order; nothing is dropped or duplicated except by reset.

Decomposition:
- Shared package scfifo_s_pkg holds:
  - MAX_READ_LATENCY=3;
  - a function clog2p1(n) for counter widths.
- One natural sub-module, scfifo_s_regbuf: a parameterised register FIFO with push/pop/count, WIDTH and DEPTH parameters, and aclr/sclr.
- The top level holds the issue logic, the latency shift register and inflight_cnt.

Test Plan:
- Streaming (READ_LATENCY=1):
  - Stimulus: preload FIFO with 0x1..0x8, hold out_ready=1.
  - Required: out_data 0x1..0x8 on 8 consecutive cycles, first valid 2 cycles after empty falls.
- Backpressure:
  - Stimulus: FIFO holds 10 words, out_ready=0.
  - Required: fifo_rdreq pulses exactly 3 times, then out_count=3, out_valid=1, out_data=first word held.
  - Then raise out_ready: remaining words arrive in order.
- Random ready:
  - Stimulus: out_ready toggles randomly over 200 words.
  - Required: scoreboard shows in-order and lossless delivery; fifo_rdreq never high while fifo_empty=1.
- Latency variant:
  - Stimulus: READ_LATENCY=3, continuous stream.
  - Required: first valid 4 cycles after empty falls, then full throughput; BUF_DEPTH=5.
- sclr mid-stream:
  - Stimulus: assert sclr with 2 in flight and 2 buffered.
  - Required: next cycle out_valid=0, out_count=0; refilled data is post-clear data only.
- aclr:
  - Stimulus: aclr pulse between clock edges.
  - Required: out_valid and fifo_rdreq drop immediately, without waiting for a clock edge.
